pos_decode_accum: RTL and testbench
===================================

// Module: pos_decode_accum
// PURPOSE
//   Inverse of the priority-encoder path. Accepts a stream of POS_W-bit bit
//   positions over a valid/ready handshake and decodes each one to one-hot.
//   ORs the one-hots into a VEC_W-bit mask for the whole frame. Presents the
//   finished mask, a beat count and a duplicate flag on a valid/ready output.
//   Sits downstream of position-producing logic, e.g. to rebuild request
//   vectors for encoder round-trip checking.
// PARAMETERS
//   POS_W  3          width of a position beat
//   VEC_W  2**POS_W   mask width; derived, do not override
//   CNT_W  POS_W+1    width of the beat counter
// PORTS
//   clk        in   1      single clock; all logic on posedge clk
//   reset      in   1      synchronous, active-high reset
//   in_valid   in   1      position beat valid
//   in_ready   out  1      block can accept a beat
//   in_pos     in   POS_W  bit position to set, 0..VEC_W-1
//   in_last    in   1      beat is the final one of the frame
//   out_valid  out  1      frame result valid
//   out_ready  in   1      consumer accepts the result
//   out_mask   out  VEC_W  OR of 1<<in_pos over all beats of the frame
//   out_count  out  CNT_W  beats in the frame; saturates at 2**CNT_W-1
//   out_dup    out  1      some position appeared more than once in the frame
// BEHAVIOUR
//   Clocking and reset
//   - All state is updated at posedge clk.
//   - reset=1 forces state=IDLE, mask=0, count=0, dup=0, out_valid=0.
//   - Reset wins over every other event, including mid-frame and while a
//     result is waiting in DONE; partial or waiting results are discarded.
//   States: IDLE (no beat yet), ACCUM (frame open), DONE (result held).
//   - in_ready = (state != DONE). out_valid = (state == DONE).
//   Beat acceptance: acc = in_valid & in_ready.
//   - onehot = 1<<in_pos.
//   - dup   <= dup | (mask[in_pos] & (state==ACCUM)).
//   - mask  <= mask | onehot.
//   - count <= (count==max) ? max : count+1.
//   - On acc with in_last=0: IDLE->ACCUM or stay in ACCUM.
//   - On acc with in_last=1: go to DONE from IDLE or ACCUM (a one-beat frame
//     is legal).
//   Latency
//   - Last beat accepted at edge N; out_valid=1 and all out_* hold final values
//     from edge N until the output handshake.
//   - out_mask, out_count and out_dup are registered and reflect the running
//     accumulation in IDLE/ACCUM; they are meaningful only when out_valid=1.
//   Output handshake
//   - In DONE with out_ready=1: next state IDLE; mask, count and dup clear to 0.
//   - In DONE with out_ready=0: hold; outputs stable; in_ready stays 0.
//   - The beat after the handshake is accepted no earlier than the next cycle;
//     no bypass.
//   Other rules
//   - in_valid with in_ready=0 is ignored. The sender must hold the beat stable
//     until it is accepted.
//   - in_pos is always in range because VEC_W=2**POS_W, so no range check.
// TESTING
//   1 After reset: out_valid=0, in_ready=1, out_mask=0, out_count=0.
//   2 Beats 0,3,7(last), one per cycle, out_ready=1 -> one cycle of out_valid
//     with mask=8'h89, count=3, dup=0; then IDLE.
//   3 Beats 5,5(last) -> mask=8'h20, count=2, dup=1.
//   4 Single beat pos=2 with last, out_ready=0 for 4 cycles -> in_ready=0,
//     result held at 8'h04/1/0, then released on out_ready=1.
//   5 20 beats cycling 0..7, last on 20th -> mask=8'hFF, count=15
//     (saturated), dup=1.
//   6 Beats 1,4 then reset=1 -> next frame 6(last) gives mask=8'h40, count=1,
//     dup=0.

Source files
------------

// File: rtl/pos_decode_accum_if.sv
// Position-in / mask-out stream bundle for pos_decode_accum.
//   in_valid/in_ready/in_pos/in_last       : position beat stream (master -> slave)
//   out_valid/out_ready/out_mask/out_count/out_dup : frame result stream (slave -> master)
// master = producer of positions and consumer of results; slave = the decoder.
interface pos_decode_accum_if #(
  parameter int unsigned POS_W = 3
);
  localparam int unsigned VEC_W = 2 ** POS_W;
  localparam int unsigned CNT_W = POS_W + 1;

  logic             in_valid;
  logic             in_ready;
  logic [POS_W-1:0] in_pos;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [VEC_W-1:0] out_mask;
  logic [CNT_W-1:0] out_count;
  logic             out_dup;

  modport master (
    output in_valid, in_pos, in_last, out_ready,
    input  in_ready, out_valid, out_mask, out_count, out_dup
  );

  modport slave (
    input  in_valid, in_pos, in_last, out_ready,
    output in_ready, out_valid, out_mask, out_count, out_dup
  );
endinterface

// File: rtl/pos_decode_accum.sv
// Decodes a stream of bit positions to one-hot and ORs them into a per-frame
// mask; presents mask, saturating beat count and duplicate flag as one result.
//   clk   : clock, all state on posedge
//   reset : synchronous active-high reset
//   bus   : slave side of pos_decode_accum_if (position in, frame result out)
module pos_decode_accum #(
  parameter int unsigned POS_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  pos_decode_accum_if.slave  bus
);
  localparam int unsigned VEC_W = 2 ** POS_W;
  localparam int unsigned CNT_W = POS_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [VEC_W-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             dup_q, dup_d;
  logic             in_ready_q, out_valid_q;
  logic [VEC_W-1:0] onehot;
  logic             acc;

  // State and accumulator registers; handshake flags are registered copies of
  // the next-state decode so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      count_q     <= '0;
      dup_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      count_q     <= count_d;
      dup_q       <= dup_d;
      in_ready_q  <= (state_d != DONE);
      out_valid_q <= (state_d == DONE);
    end
  end

  // Next-state and accumulation.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    count_d = count_q;
    dup_d   = dup_q;
    onehot  = VEC_W'(1) << bus.in_pos;
    acc     = bus.in_valid & in_ready_q;

    case (state_q)
      IDLE, ACCUM: begin
        if (acc) begin
          // In IDLE the mask is empty, so only an open frame can see a repeat.
          dup_d   = dup_q | (mask_q[bus.in_pos] & (state_q == ACCUM));
          mask_d  = mask_q | onehot;
          count_d = (count_q == CNT_MAX) ? CNT_MAX : count_q + CNT_W'(1);
          state_d = bus.in_last ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          mask_d  = '0;
          count_d = '0;
          dup_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        mask_d  = '0;
        count_d = '0;
        dup_d   = 1'b0;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_mask  = mask_q;
  assign bus.out_count = count_q;
  assign bus.out_dup   = dup_q;
endmodule

// File: tb/tb_pos_decode_accum.sv
// Randomized and directed bench for pos_decode_accum against a frame-level
// reference model (a queue of accepted positions per frame).
module tb_pos_decode_accum;
  logic clk;
  logic reset;

  pos_decode_accum_if #(.POS_W(3)) bus ();

  pos_decode_accum #(.POS_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: positions accepted in the current frame, and whether
  // the frame has been closed and awaits the consumer.
  int frame[$];
  bit done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_mask();
    logic [7:0] m = '0;
    foreach (frame[i]) m[frame[i]] = 1'b1;
    return m;
  endfunction

  function automatic logic [3:0] m_count();
    return (frame.size() > 15) ? 4'd15 : 4'(frame.size());
  endfunction

  function automatic logic m_dup();
    for (int i = 0; i < frame.size(); i++)
      for (int j = i + 1; j < frame.size(); j++)
        if (frame[i] == frame[j]) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: apply inputs, advance model at the edge, compare at negedge.
  task automatic cycle(input logic v, input logic [2:0] p, input logic l,
                       input logic r, input logic rs);
    bus.in_valid  = v;
    bus.in_pos    = p;
    bus.in_last   = l;
    bus.out_ready = r;
    reset         = rs;
    @(posedge clk);
    if (rs) begin
      frame.delete();
      done = 1'b0;
    end else if (done) begin
      if (r) begin
        frame.delete();
        done = 1'b0;
      end
    end else if (v) begin
      frame.push_back(int'(p));
      if (l) done = 1'b1;
    end
    @(negedge clk);
    check("out_valid", 32'(bus.out_valid), 32'(done));
    check("in_ready",  32'(bus.in_ready),  32'(!done));
    check("out_mask",  32'(bus.out_mask),  32'(m_mask()));
    check("out_count", 32'(bus.out_count), 32'(m_count()));
    check("out_dup",   32'(bus.out_dup),   32'(m_dup()));
  endtask

  logic       cv, cl, cr, crs;
  logic [2:0] cp;

  initial begin
    done = 1'b0;
    bus.in_valid = 1'b0; bus.in_pos = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    // Reset state
    cycle(0, 0, 0, 0, 1);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_ready", 32'(bus.in_ready),  32'd1);
    check("rst_mask",  32'(bus.out_mask),  32'd0);
    check("rst_count", 32'(bus.out_count), 32'd0);

    // Frame 0,3,7
    cycle(1, 0, 0, 1, 0);
    cycle(1, 3, 0, 1, 0);
    cycle(1, 7, 1, 1, 0);
    check("f1_valid", 32'(bus.out_valid), 32'd1);
    check("f1_mask",  32'(bus.out_mask),  32'h89);
    check("f1_count", 32'(bus.out_count), 32'd3);
    check("f1_dup",   32'(bus.out_dup),   32'd0);
    cycle(0, 0, 0, 1, 0);
    check("f1_idle", 32'(bus.out_valid), 32'd0);

    // Frame 5,5
    cycle(1, 5, 0, 1, 0);
    cycle(1, 5, 1, 1, 0);
    check("f2_mask",  32'(bus.out_mask),  32'h20);
    check("f2_count", 32'(bus.out_count), 32'd2);
    check("f2_dup",   32'(bus.out_dup),   32'd1);
    cycle(0, 0, 0, 1, 0);

    // Single beat held under backpressure
    cycle(1, 2, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0, 0);
      check("f3_hold_ready", 32'(bus.in_ready), 32'd0);
      check("f3_hold_mask",  32'(bus.out_mask), 32'h04);
      check("f3_hold_count", 32'(bus.out_count), 32'd1);
      check("f3_hold_dup",   32'(bus.out_dup),  32'd0);
    end
    cycle(0, 0, 0, 1, 0);
    check("f3_release", 32'(bus.out_valid), 32'd0);

    // 20 beats, count saturates
    for (int i = 0; i < 20; i++) cycle(1, 3'(i % 8), (i == 19), 1, 0);
    check("f4_mask",  32'(bus.out_mask),  32'hFF);
    check("f4_count", 32'(bus.out_count), 32'd15);
    check("f4_dup",   32'(bus.out_dup),   32'd1);
    cycle(0, 0, 0, 1, 0);

    // Reset mid-frame discards partial result
    cycle(1, 1, 0, 1, 0);
    cycle(1, 4, 0, 1, 0);
    cycle(0, 0, 0, 1, 1);
    cycle(1, 6, 1, 1, 0);
    check("f5_mask",  32'(bus.out_mask),  32'h40);
    check("f5_count", 32'(bus.out_count), 32'd1);
    check("f5_dup",   32'(bus.out_dup),   32'd0);
    cycle(0, 0, 0, 1, 0);

    // Randomized traffic; a beat offered while not ready is held stable.
    cv = 0; cp = 0; cl = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!(cv && done)) begin
        cv = ($urandom_range(0, 3) != 0);
        cp = 3'($urandom_range(0, 7));
        cl = ($urandom_range(0, 4) == 0);
      end
      cr  = ($urandom_range(0, 1) == 1);
      crs = ($urandom_range(0, 99) == 0);
      cycle(cv, cp, cl, cr, crs);
      if (crs) cv = 0;
      else if (cv && !done && !crs) cv = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
